// File: rtl/complement_to_2_seq_pkg.sv
// rtl/complement_to_2_seq_pkg.sv - shared states and helpers for the serial two's-complement converter
package complement_pkg;

  localparam int MAX_W = 64;

  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t CONV = 2'd1;
  localparam state_t DONE = 2'd2;

  function automatic int num_digits(input int w, input int digit_w);
    return w / digit_w;
  endfunction

  // A single-digit word still needs a one-bit counter
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [MAX_W-1:0] most_negative(input int w);
    logic [MAX_W-1:0] v;
    v = '0;
    v[w-1] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/complement_to_2_seq_serial_negate_slice.sv
// rtl/complement_to_2_seq_serial_negate_slice.sv - one digit of ~a + carry for a single operand
module serial_negate_slice #(
  parameter int DIGIT_W = 1
) (
  input  logic [DIGIT_W-1:0] digit_in,
  input  logic               carry_in,
  input  logic               mask,
  output logic [DIGIT_W-1:0] digit_out,
  output logic               carry_out
);

  logic [DIGIT_W:0] sum;

  assign sum       = {1'b0, ~digit_in} + {{DIGIT_W{1'b0}}, carry_in};
  assign digit_out = mask ? sum[DIGIT_W-1:0] : digit_in;
  assign carry_out = mask ? sum[DIGIT_W] : carry_in;

endmodule

// File: rtl/complement_to_2_seq.sv
// rtl/complement_to_2_seq.sv - digit-serial two's-complement converter; TWOS_SAT_EN saturates negated most-negative values
module complement_to_2_seq #(
  parameter int W       = 8,
  parameter int NUM_OPS = 2,
  parameter int OP_W    = 4,
  parameter int DIGIT_W = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NUM_OPS*W+OP_W-1:0] in_data,
  input  logic [NUM_OPS-1:0]      neg_mask,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [NUM_OPS*W-1:0]    out_ops,
  output logic [OP_W-1:0]         out_op,
  output logic [NUM_OPS-1:0]      out_ovf,
  output logic                    busy
);

  import complement_pkg::*;

  localparam int              NUM_DIGITS = num_digits(W, DIGIT_W);
  localparam int              CNT_W      = cnt_width(NUM_DIGITS);
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(NUM_DIGITS - 1);
  localparam logic [W-1:0]    MOST_NEG   = W'(most_negative(W));

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic [NUM_OPS-1:0]   carry_q;
  logic [NUM_OPS-1:0]   mask_q;
  logic [NUM_OPS-1:0]   carry_next;
  logic [NUM_OPS-1:0]   ovf_next;
  logic [OP_W-1:0]      op_q;
  logic [W-1:0]         ops_q     [NUM_OPS];
  logic [W-1:0]         ops_shift [NUM_OPS];
  logic [NUM_OPS*W-1:0] res_next;
  logic                 accept;
  logic                 last_digit;

  assign in_ready   = (state == IDLE) | ((state == DONE) & out_ready);
  assign accept     = in_valid & in_ready;
  assign out_valid  = (state == DONE);
  assign busy       = (state != IDLE);
  assign last_digit = (cnt == LAST_CNT);

  // Field p (p=0 is the lowest operand field) pairs with mask/ovf bit p.
  // Each operand register rotates right one digit per cycle, so after
  // NUM_DIGITS cycles every converted digit is back in its home position.
  for (genvar p = 0; p < NUM_OPS; p++) begin : g_op
    logic [DIGIT_W-1:0] digit_out;
    logic [W-1:0]       res_op;

    serial_negate_slice #(
      .DIGIT_W(DIGIT_W)
    ) u_slice (
      .digit_in (ops_q[p][DIGIT_W-1:0]),
      .carry_in (carry_q[p]),
      .mask     (mask_q[p]),
      .digit_out(digit_out),
      .carry_out(carry_next[p])
    );

    assign ops_shift[p] = W'({digit_out, ops_q[p]} >> DIGIT_W);
    // Only the most-negative input negates to itself
    assign ovf_next[p]  = mask_q[p] & (ops_shift[p] == MOST_NEG);

`ifdef TWOS_SAT_EN
    assign res_op = ovf_next[p] ? ~MOST_NEG : ops_shift[p];
`else
    assign res_op = ops_shift[p];
`endif

    assign res_next[p*W +: W] = res_op;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      carry_q <= '1;
      mask_q  <= '0;
      op_q    <= '0;
      out_ops <= '0;
      out_op  <= '0;
      out_ovf <= '0;
      for (int i = 0; i < NUM_OPS; i++) ops_q[i] <= '0;
    end else if (accept) begin
      state   <= CONV;
      cnt     <= '0;
      carry_q <= '1;
      mask_q  <= neg_mask;
      op_q    <= in_data[OP_W-1:0];
      for (int i = 0; i < NUM_OPS; i++) ops_q[i] <= in_data[OP_W + i*W +: W];
    end else begin
      case (state)
        CONV: begin
          cnt     <= cnt + CNT_W'(1);
          carry_q <= carry_next;
          for (int i = 0; i < NUM_OPS; i++) ops_q[i] <= ops_shift[i];
          if (last_digit) begin
            state   <= DONE;
            out_ops <= res_next;
            out_op  <= op_q;
            out_ovf <= ovf_next;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        IDLE: ;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_complement_to_2_seq.sv
// tb/tb_complement_to_2_seq.sv - directed-vector bench for complement_to_2_seq
module tb_complement_to_2_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready, busy;
  logic [19:0] in_data;
  logic [1:0]  neg_mask, out_ovf;
  logic [15:0] out_ops;
  logic [3:0]  out_op;

  logic        in_valid4, in_ready4, out_valid4, out_ready4, busy4;
  logic [51:0] in_data4;
  logic [2:0]  neg_mask4, out_ovf4;
  logic [47:0] out_ops4;
  logic [3:0]  out_op4;

  int vec_count = 0;
  int err_count = 0;

`ifdef TWOS_SAT_EN
  localparam logic [15:0] EXP_MN8  = 16'h7FFF;
  localparam logic [47:0] EXP_MN16 = 48'h7FFF_0000_FFFB;
`else
  localparam logic [15:0] EXP_MN8  = 16'h80FF;
  localparam logic [47:0] EXP_MN16 = 48'h8000_0000_FFFB;
`endif

  always #5 clk = ~clk;

  complement_to_2_seq u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .neg_mask(neg_mask), .out_valid(out_valid),
    .out_ready(out_ready), .out_ops(out_ops), .out_op(out_op),
    .out_ovf(out_ovf), .busy(busy)
  );

  complement_to_2_seq #(.W(16), .NUM_OPS(3), .OP_W(4), .DIGIT_W(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
    .in_data(in_data4), .neg_mask(neg_mask4), .out_valid(out_valid4),
    .out_ready(out_ready4), .out_ops(out_ops4), .out_op(out_op4),
    .out_ovf(out_ovf4), .busy(busy4)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec_count++;
    if (got !== exp) begin
      err_count++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic run_word(input string tag, input logic [19:0] din, input logic [1:0] m,
                          input logic [15:0] eops, input logic [1:0] eovf);
    int n;
    @(negedge clk);
    in_valid = 1'b1; in_data = din; neg_mask = m;
    #1 check({tag, " in_ready"}, in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_data = '0; neg_mask = '0;
    wait_valid(n);
    check({tag, " latency"}, n, 8);
    check({tag, " ops"}, out_ops, eops);
    check({tag, " op"}, out_op, din[3:0]);
    check({tag, " ovf"}, out_ovf, eovf);
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    check({tag, " idle valid"}, out_valid, 0);
    check({tag, " idle busy"}, busy, 0);
  endtask

  task automatic run4(input string tag, input logic [51:0] din, input logic [2:0] m,
                      input logic [47:0] eops, input logic [2:0] eovf);
    int n;
    @(negedge clk);
    in_valid4 = 1'b1; in_data4 = din; neg_mask4 = m;
    @(posedge clk); #1;
    in_valid4 = 1'b0;
    n = 0;
    while (!out_valid4 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, " latency"}, n, 4);
    check({tag, " ops"}, out_ops4, eops);
    check({tag, " op"}, out_op4, din[3:0]);
    check({tag, " ovf"}, out_ovf4, eovf);
    @(negedge clk); out_ready4 = 1'b1;
    @(posedge clk); #1; out_ready4 = 1'b0;
  endtask

  initial begin
    int n;
    rst = 1'b1;
    in_valid = 0; in_data = '0; neg_mask = '0; out_ready = 0;
    in_valid4 = 0; in_data4 = '0; neg_mask4 = '0; out_ready4 = 0;
    #1;
    check("rst out_valid", out_valid, 0);
    check("rst busy", busy, 0);
    check("rst in_ready", in_ready, 1);
    check("rst out_ops", out_ops, 0);
    check("rst out_ovf", out_ovf, 0);
    check("rst out_valid4", out_valid4, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    run_word("neg both", 20'h0503A, 2'b11, 16'hFBFD, 2'b00);
    run_word("pass 7f",  20'h007F3, 2'b01, 16'h0081, 2'b00);
    run_word("neg zero", 20'h00555, 2'b10, 16'h0055, 2'b00);
    run_word("most neg", 20'h80017, 2'b11, EXP_MN8,  2'b10);
    run_word("no mask",  20'h80C31, 2'b00, 16'h80C3, 2'b00);

    // Backpressure in DONE, then a zero-bubble back-to-back accept
    @(negedge clk);
    in_valid = 1'b1; in_data = 20'h12349; neg_mask = 2'b11;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_valid(n);
    check("bp latency", n, 8);
    for (int k = 0; k < 5; k++) begin
      check("bp ops", out_ops, 16'hEECC);
      check("bp op", out_op, 4'h9);
      check("bp valid", out_valid, 1);
      check("bp in_ready", in_ready, 0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; in_data = 20'h02FE4; neg_mask = 2'b11;
    #1 check("b2b in_ready", in_ready, 1);
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b0;
    check("b2b busy", busy, 1);
    check("b2b valid", out_valid, 0);
    wait_valid(n);
    check("b2b latency", n, 8);
    check("b2b ops", out_ops, 16'hFE02);
    check("b2b op", out_op, 4'h4);
    check("b2b ovf", out_ovf, 2'b00);

    // Reset while converting a new word (cnt = 4)
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; in_data = 20'h0A0B5; neg_mask = 2'b11;
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("mid rst valid", out_valid, 0);
    check("mid rst busy", busy, 0);
    check("mid rst ops", out_ops, 0);
    check("mid rst op", out_op, 0);
    check("mid rst ovf", out_ovf, 0);
    check("mid rst in_ready", in_ready, 1);
    @(negedge clk); rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      check("post rst no valid", out_valid, 0);
    end
    run_word("post rst", 20'h02021, 2'b11, 16'hFEFE, 2'b00);

    run4("w16 d4", 52'h0001_1234_FFFF_6, 3'b111, 48'hFFFF_EDCC_0001, 3'b000);
    run4("w16 mn", 52'h8000_0000_0005_C, 3'b111, EXP_MN16, 3'b100);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end

endmodule
